// File: rtl/image_seq_loader.sv
// Image sequencer between the image ROM and the VGA display RAM port.
// It copies one image at a time from the synchronous ROM into the display RAM.
// It then holds that image for a frame period before loading the next one.
module image_seq_loader #(
    parameter  int unsigned DATA_W       = 16,
    parameter  int unsigned IMG_WORDS    = 16,
    parameter  int unsigned IMG_NUM      = 16,
    parameter  int unsigned ROM_LAT      = 1,
    parameter  int unsigned FRAME_CYCLES = 6_250_000,
    localparam int unsigned WA_W = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1,
    localparam int unsigned IX_W = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1,
    localparam int unsigned RA_W = (IMG_NUM * IMG_WORDS > 1) ? $clog2(IMG_NUM * IMG_WORDS) : 1
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pause,
    input  logic [1:0]        mode,
    output logic [RA_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              write_en,
    output logic [WA_W-1:0]   write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [IX_W-1:0]   image_index,
    output logic              busy,
    output logic              load_done,
    output logic              seq_end
);

    localparam int unsigned CNT_W     = $clog2(IMG_WORDS + ROM_LAT + 1);
    localparam int unsigned TM_W      = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned LOAD_LAST = IMG_WORDS + ROM_LAT - 1;
    localparam logic [1:0]  MODE_PING = 2'd1;
    localparam logic [1:0]  MODE_ONE  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [TM_W-1:0]   timer;
    logic              dir_down;
    logic [1:0]        mode_q;
    logic              enable_q;
    logic [ROM_LAT-1:0] vld_pipe;
    logic [WA_W-1:0]   w_pipe [ROM_LAT];

    logic              issue_c;
    logic              restart_c;
    logic              frame_end_c;
    logic              at_end_c;
    logic              nxt_dir_c;
    logic [IX_W-1:0]   nxt_idx_c;

    // First ROM word address of an image
    function automatic logic [RA_W-1:0] base_of(input logic [IX_W-1:0] idx);
        return RA_W'(idx) * RA_W'(IMG_WORDS);
    endfunction

    assign write_data  = rom_data;
    assign write_en    = vld_pipe[ROM_LAT-1];
    assign write_addr  = w_pipe[ROM_LAT-1];
    assign issue_c     = (state == S_LOAD) && (cnt < CNT_W'(IMG_WORDS));
    assign restart_c   = seq_end && ((mode != mode_q) || (enable && !enable_q));
    assign frame_end_c = (state == S_HOLD) && !pause && (timer == TM_W'(FRAME_CYCLES - 1));

    // Next image index and ping-pong direction for the current mode
    always_comb begin
        nxt_idx_c = image_index;
        nxt_dir_c = dir_down;
        at_end_c  = 1'b0;
        if (IMG_NUM > 1) begin
            case (mode)
                MODE_PING: begin
                    if (!dir_down) begin
                        if (image_index == IX_W'(IMG_NUM - 1)) begin
                            nxt_idx_c = image_index - IX_W'(1);
                            nxt_dir_c = 1'b1;
                        end else begin
                            nxt_idx_c = image_index + IX_W'(1);
                        end
                    end else begin
                        if (image_index == '0) begin
                            nxt_idx_c = image_index + IX_W'(1);
                            nxt_dir_c = 1'b0;
                        end else begin
                            nxt_idx_c = image_index - IX_W'(1);
                        end
                    end
                end
                MODE_ONE: begin
                    if (image_index == IX_W'(IMG_NUM - 1)) begin
                        at_end_c = 1'b1;
                    end else begin
                        nxt_idx_c = image_index + IX_W'(1);
                    end
                end
                default: begin
                    if (image_index == IX_W'(IMG_NUM - 1)) begin
                        nxt_idx_c = '0;
                    end else begin
                        nxt_idx_c = image_index + IX_W'(1);
                    end
                end
            endcase
        end else begin
            at_end_c = (mode == MODE_ONE);
        end
    end

    // Sequencer FSM: idle, image load, frame hold
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            timer       <= '0;
            dir_down    <= 1'b0;
            mode_q      <= '0;
            enable_q    <= 1'b0;
            rom_addr    <= '0;
            image_index <= '0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            seq_end     <= 1'b0;
        end else begin
            mode_q    <= mode;
            enable_q  <= enable;
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (restart_c) begin
                        seq_end     <= 1'b0;
                        image_index <= '0;
                        dir_down    <= 1'b0;
                    end
                    if (enable) begin
                        state    <= S_LOAD;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        timer    <= '0;
                        rom_addr <= restart_c ? '0 : base_of(image_index);
                    end
                end
                S_LOAD: begin
                    timer <= timer + TM_W'(1);
                    if (cnt < CNT_W'(IMG_WORDS - 1)) begin
                        rom_addr <= rom_addr + RA_W'(1);
                    end
                    if (cnt == CNT_W'(LOAD_LAST)) begin
                        state     <= S_HOLD;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (restart_c) begin
                        seq_end     <= 1'b0;
                        image_index <= '0;
                        dir_down    <= 1'b0;
                        if (enable) begin
                            state    <= S_LOAD;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            timer    <= '0;
                            rom_addr <= '0;
                        end
                    end else if (frame_end_c) begin
                        timer       <= '0;
                        image_index <= nxt_idx_c;
                        dir_down    <= nxt_dir_c;
                        if (at_end_c) begin
                            seq_end <= 1'b1;
                        end
                        if (!enable) begin
                            state <= S_IDLE;
                        end else if (!at_end_c) begin
                            state    <= S_LOAD;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            rom_addr <= base_of(nxt_idx_c);
                        end
                    end else if (!pause) begin
                        timer <= timer + TM_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write pipe: delays issue valid and word index by the ROM latency
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < int'(ROM_LAT); i++) begin
                w_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= issue_c;
            w_pipe[0]   <= WA_W'(cnt);
            for (int i = 1; i < int'(ROM_LAT); i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                w_pipe[i]   <= w_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_image_seq_loader.sv
// Directed bench for image_seq_loader: 4 images of 4 words, 16-cycle frames.
// ROM word k holds 16'hA000+k; extra instances run with ROM latency 2 and 3.
module tb_image_seq_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, pause;
    logic [1:0]  mode;

    logic [3:0]  rom_addr, a2_rom_addr, a3_rom_addr;
    logic [15:0] rom_data, a2_rom_data, a3_rom_data;
    logic        write_en, a2_write_en, a3_write_en;
    logic [1:0]  write_addr, a2_write_addr, a3_write_addr;
    logic [15:0] write_data, a2_write_data, a3_write_data;
    logic [1:0]  image_index, a2_image_index, a3_image_index;
    logic        busy, a2_busy, a3_busy;
    logic        load_done, a2_load_done, a3_load_done;
    logic        seq_end, a2_seq_end, a3_seq_end;

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    bit busy_prev = 1'b0;
    bit rise      = 1'b0;

    image_seq_loader #(.DATA_W(16), .IMG_WORDS(4), .IMG_NUM(4), .ROM_LAT(1), .FRAME_CYCLES(16)) dut (
        .vga_clk(clk), .rst(rst), .enable(enable), .pause(pause), .mode(mode),
        .rom_addr(rom_addr), .rom_data(rom_data), .write_en(write_en),
        .write_addr(write_addr), .write_data(write_data), .image_index(image_index),
        .busy(busy), .load_done(load_done), .seq_end(seq_end)
    );

    image_seq_loader #(.DATA_W(16), .IMG_WORDS(4), .IMG_NUM(4), .ROM_LAT(2), .FRAME_CYCLES(16)) dut_l2 (
        .vga_clk(clk), .rst(rst), .enable(enable), .pause(pause), .mode(mode),
        .rom_addr(a2_rom_addr), .rom_data(a2_rom_data), .write_en(a2_write_en),
        .write_addr(a2_write_addr), .write_data(a2_write_data), .image_index(a2_image_index),
        .busy(a2_busy), .load_done(a2_load_done), .seq_end(a2_seq_end)
    );

    image_seq_loader #(.DATA_W(16), .IMG_WORDS(4), .IMG_NUM(4), .ROM_LAT(3), .FRAME_CYCLES(16)) dut_l3 (
        .vga_clk(clk), .rst(rst), .enable(enable), .pause(pause), .mode(mode),
        .rom_addr(a3_rom_addr), .rom_data(a3_rom_data), .write_en(a3_write_en),
        .write_addr(a3_write_addr), .write_data(a3_write_data), .image_index(a3_image_index),
        .busy(a3_busy), .load_done(a3_load_done), .seq_end(a3_seq_end)
    );

    // Synchronous ROM models with latency 1, 2 and 3
    logic [15:0] rom1_q;
    logic [15:0] rom2_q [2];
    logic [15:0] rom3_q [3];
    always @(posedge clk) begin
        rom1_q    <= 16'hA000 + 16'(rom_addr);
        rom2_q[0] <= 16'hA000 + 16'(a2_rom_addr);
        rom2_q[1] <= rom2_q[0];
        rom3_q[0] <= 16'hA000 + 16'(a3_rom_addr);
        rom3_q[1] <= rom3_q[0];
        rom3_q[2] <= rom3_q[1];
    end
    assign rom_data    = rom1_q;
    assign a2_rom_data = rom2_q[1];
    assign a3_rom_data = rom3_q[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and check every RAM write against the ROM image
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rise      = busy && !busy_prev;
        busy_prev = busy;
        if (write_en)
            chk("wdata_l1", 32'(write_data), 32'hA000 + 32'(image_index) * 4 + 32'(write_addr));
        if (a2_write_en)
            chk("wdata_l2", 32'(a2_write_data), 32'hA000 + 32'(a2_image_index) * 4 + 32'(a2_write_addr));
        if (a3_write_en)
            chk("wdata_l3", 32'(a3_write_data), 32'hA000 + 32'(a3_image_index) * 4 + 32'(a3_write_addr));
    endtask

    // Step until busy rises (LOAD entry), bounded
    task automatic wait_entry(output int at);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!rise && n < 200);
        chk("entry_seen", 32'(rise), 32'd1);
        at = cyc;
    endtask

    initial begin
        int e_prev, at, nwe;
        int exp2[4];
        int exp3[7];
        exp2 = '{1, 2, 3, 0};
        exp3 = '{1, 2, 3, 2, 1, 0, 1};

        // Reset state
        rst = 1'b1; enable = 1'b0; pause = 1'b0; mode = 2'd0;
        step(); step();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_write_addr", 32'(write_addr), 32'd0);
        chk("rst_image_index", 32'(image_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_seq_end", 32'(seq_end), 32'd0);

        // 1: first load of image 0
        rst = 1'b0; enable = 1'b1;
        step();
        e_prev = cyc;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) chk("t1_rom_addr", 32'(rom_addr), 32'(k));
            chk("t1_write_en", 32'(write_en), 32'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) begin
                chk("t1_write_addr", 32'(write_addr), 32'(k - 1));
                chk("t1_write_data", 32'(write_data), 32'hA000 + 32'(k - 1));
            end
            chk("t1_busy", 32'(busy), 32'(k <= 4));
            chk("t1_load_done", 32'(load_done), 32'(k == 5));
            if (k < 5) step();
        end

        // 2: loop mode, 16-cycle period
        for (int f = 0; f < 4; f++) begin
            wait_entry(at);
            chk("t2_index", 32'(image_index), 32'(exp2[f]));
            chk("t2_period", 32'(at - e_prev), 32'd16);
            e_prev = at;
            if (f == 0) begin
                for (int k = 0; k < 4; k++) begin
                    step();
                    chk("t2_img1_we", 32'(write_en), 32'd1);
                    chk("t2_img1_data", 32'(write_data), 32'hA004 + 32'(k));
                end
            end
        end

        // 3: ping-pong
        mode = 2'd1;
        for (int f = 0; f < 7; f++) begin
            wait_entry(at);
            chk("t3_index", 32'(image_index), 32'(exp3[f]));
            chk("t3_period", 32'(at - e_prev), 32'd16);
            e_prev = at;
            if (f == 3) begin
                for (int k = 0; k < 4; k++) begin
                    step();
                    chk("t3_down_data", 32'(write_data), 32'hA008 + 32'(k));
                end
            end
        end

        // 4: one-shot
        rst = 1'b1; mode = 2'd2;
        step();
        rst = 1'b0;
        for (int f = 0; f < 4; f++) begin
            wait_entry(at);
            chk("t4_index", 32'(image_index), 32'(f));
        end
        for (int k = 0; k < 15; k++) step();
        chk("t4_seq_end_early", 32'(seq_end), 32'd0);
        step();
        chk("t4_seq_end", 32'(seq_end), 32'd1);
        chk("t4_hold_index", 32'(image_index), 32'd3);
        nwe = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (write_en) nwe++;
        end
        chk("t4_no_writes", 32'(nwe), 32'd0);
        chk("t4_seq_end_held", 32'(seq_end), 32'd1);
        enable = 1'b0;
        step();
        enable = 1'b1;
        wait_entry(at);
        chk("t4_restart_index", 32'(image_index), 32'd0);
        chk("t4_restart_seq_end", 32'(seq_end), 32'd0);
        chk("t4_restart_rom_addr", 32'(rom_addr), 32'd0);

        // 5: pause in HOLD stretches the frame; pause in LOAD does not
        rst = 1'b1; mode = 2'd0;
        step();
        rst = 1'b0;
        wait_entry(at);
        wait_entry(at);
        e_prev = at;
        chk("t5_index1", 32'(image_index), 32'd1);
        for (int k = 0; k < 6; k++) step();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) step();
        pause = 1'b0;
        wait_entry(at);
        chk("t5_paused_period", 32'(at - e_prev), 32'd26);
        chk("t5_index2", 32'(image_index), 32'd2);
        e_prev = at;
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_load_we", 32'(write_en), 32'd1);
            chk("t5_load_data", 32'(write_data), 32'hA008 + 32'(k));
        end
        step();
        chk("t5_load_done", 32'(load_done), 32'd1);
        pause = 1'b0;
        wait_entry(at);
        chk("t5_period_after", 32'(at - e_prev), 32'd16);
        chk("t5_index3", 32'(image_index), 32'd3);

        // 6: asynchronous reset in the middle of a load
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_entry(at);
        wait_entry(at);
        wait_entry(at);
        chk("t6_index2", 32'(image_index), 32'd2);
        step(); step();
        chk("t6_second_we", 32'(write_en), 32'd1);
        chk("t6_second_addr", 32'(write_addr), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_we", 32'(write_en), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_rom_addr", 32'(rom_addr), 32'd0);
        chk("t6_async_index", 32'(image_index), 32'd0);
        chk("t6_async_waddr", 32'(write_addr), 32'd0);
        step();
        rst = 1'b0;
        wait_entry(at);
        chk("t6_reload_index", 32'(image_index), 32'd0);
        nwe = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (write_en) begin
                chk("t6_reload_addr", 32'(write_addr), 32'(nwe));
                nwe++;
            end
        end
        chk("t6_reload_count", 32'(nwe), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
